// File: rtl/reg_file_mp_pkg.sv
// Shared types, default widths and parity helper for the multi-port register file.
package reg_file_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned PAR_MAX_W  = 64;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

  // Even-parity bit over a word zero-extended to PAR_MAX_W (zero padding leaves parity unchanged).
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: ready gating, zero register, write bypass, optional parity check.
// Parity checking is present when REG_FILE_MP_PARITY_EN is defined.
module rf_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wr_fwd,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
`ifdef REG_FILE_MP_PARITY_EN
  input  logic              rpar,
  output logic              perr,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic is_zero;
  logic is_byp;

  assign is_zero = (ZERO_REG != 0) && (raddr == '0);
  assign is_byp  = (BYPASS != 0) && wr_fwd && (raddr == waddr) && !is_zero;

  always_comb begin
    rdata = '0;
    if (ready && !is_zero) begin
      rdata = is_byp ? wdata : rword;
    end
  end

`ifdef REG_FILE_MP_PARITY_EN
  // Only words actually coming from storage are checked.
  assign perr = ready && !is_zero && !is_byp &&
                (even_par(PAR_MAX_W'(rword)) != rpar);
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass, optional zero register and sequential clear engine.
// Define REG_FILE_MP_PARITY_EN to add per-entry parity storage and the parity_err output.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_reg,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_reg,
  output logic [NUM_RD*DATA_W-1:0] read_data,
`ifdef REG_FILE_MP_PARITY_EN
  output logic [NUM_RD-1:0]        parity_err,
`endif
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef REG_FILE_MP_PARITY_EN
  localparam int unsigned STORE_W = DATA_W + 1;
`else
  localparam int unsigned STORE_W = DATA_W;
`endif

  rf_state_t          state;
  logic [CNT_W-1:0]   clr_cnt;
  logic [STORE_W-1:0] mem [DEPTH];

  logic               wr_fwd;
  logic               wr_ok;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [STORE_W-1:0] mem_wdata;

  // A write is live this cycle only when ready and not displaced by an accepted clear.
  assign wr_fwd = ready && reg_write && !clear_req;
  assign wr_ok  = wr_fwd && !((ZERO_REG != 0) && (write_reg == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= reg_write && (!ready || clear_req);
      case (state)
        CLEAR: begin
          if (clr_cnt == CNT_W'(DEPTH - 1)) begin
            state   <= READY;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage port: the clear engine owns it in CLEAR; reset itself never writes the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = write_reg;
`ifdef REG_FILE_MP_PARITY_EN
    mem_wdata = {even_par(PAR_MAX_W'(write_data)), write_data};
`else
    mem_wdata = write_data;
`endif
    if (state == CLEAR) begin
      mem_we    = rst_n;
      mem_addr  = clr_cnt[ADDR_W-1:0];
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0]  raddr;
    logic [STORE_W-1:0] rentry;

    assign raddr  = read_reg[k*ADDR_W +: ADDR_W];
    assign rentry = mem[raddr];

    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .ready (ready),
      .raddr (raddr),
      .waddr (write_reg),
      .wr_fwd(wr_fwd),
      .wdata (write_data),
      .rword (rentry[DATA_W-1:0]),
`ifdef REG_FILE_MP_PARITY_EN
      .rpar  (rentry[DATA_W]),
      .perr  (parity_err[k]),
`endif
      .rdata (read_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expectations per cycle, a negedge monitor checks them.
module tb_reg_file_mp;

  localparam int K_RD0   = 0;
  localparam int K_RD1   = 1;
  localparam int K_READY = 2;
  localparam int K_DROP  = 3;
  localparam int K_PERR0 = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [9:0]  read_reg;
  logic [63:0] read_data;
  logic        ready;
  logic        wr_drop;
`ifdef REG_FILE_MP_PARITY_EN
  logic [1:0]  parity_err;
`endif

  exp_t sb[$];
  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_file_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_reg  (read_reg),
    .read_data (read_data),
`ifdef REG_FILE_MP_PARITY_EN
    .parity_err(parity_err),
`endif
    .ready     (ready),
    .wr_drop   (wr_drop)
  );

  function automatic string kname(input int k);
    case (k)
      K_RD0:   return "read_data0";
      K_RD1:   return "read_data1";
      K_READY: return "ready";
      K_DROP:  return "wr_drop";
      default: return "parity_err0";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_RD0:   return read_data[31:0];
      K_RD1:   return read_data[63:32];
      K_READY: return {31'd0, ready};
      K_DROP:  return {31'd0, wr_drop};
`ifdef REG_FILE_MP_PARITY_EN
      K_PERR0: return {31'd0, parity_err[0]};
`endif
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic expect_now(input int kind, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = sb.pop_front();
      a = actual(e.kind);
      applied++;
      if (e.cyc != cyc || a !== e.val) begin
        miscompares++;
        $display("FAIL %s cyc=%0d (due %0d): got %h, expected %h",
                 kname(e.kind), cyc, e.cyc, a, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d expectations pending", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    clear_req  = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg   = '0;

    // Reset sequence: ready low for exactly 32 cycles after release.
    repeat (3) tick();
    rst_n = 1'b1;
    expect_now(K_DROP, 32'd0);
    for (int k = 0; k <= 32; k++) begin
      expect_now(K_READY, (k == 32) ? 32'd1 : 32'd0);
      if (k < 32) tick();
    end
    for (int i = 0; i < 16; i++) begin
      read_reg = {5'(2 * i + 1), 5'(2 * i)};
      expect_now(K_RD0, 32'd0);
      expect_now(K_RD1, 32'd0);
      tick();
    end

    // Write r5 with same-cycle bypass, then stored read.
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
    read_reg = {5'd6, 5'd5};
    expect_now(K_RD0, 32'hDEAD_BEEF);
    expect_now(K_RD1, 32'd0);
    tick();
    write_reg = 5'd6; write_data = 32'h0000_1234;
    expect_now(K_RD0, 32'hDEAD_BEEF);
    expect_now(K_RD1, 32'h0000_1234);
    expect_now(K_DROP, 32'd0);
    tick();
    reg_write = 1'b0;
    expect_now(K_RD0, 32'hDEAD_BEEF);
    expect_now(K_RD1, 32'h0000_1234);
    tick();

    // Zero register ignores writes silently.
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
    read_reg = {5'd5, 5'd0};
    expect_now(K_RD0, 32'd0);
    expect_now(K_RD1, 32'hDEAD_BEEF);
    tick();
    reg_write = 1'b0;
    expect_now(K_RD0, 32'd0);
    expect_now(K_DROP, 32'd0);
    tick();

    // Clear request with a simultaneous write to r7; a second clear_req mid-clear is ignored.
    clear_req = 1'b1; reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hA5A5_A5A5;
    read_reg = {5'd5, 5'd7};
    expect_now(K_RD0, 32'd0);
    expect_now(K_RD1, 32'hDEAD_BEEF);
    tick();
    clear_req = 1'b0; reg_write = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      expect_now(K_READY, (k == 32) ? 32'd1 : 32'd0);
      if (k == 0) begin
        expect_now(K_DROP, 32'd1);
        expect_now(K_RD1, 32'd0);
      end
      if (k == 6) expect_now(K_DROP, 32'd1);
      if (k == 7) expect_now(K_DROP, 32'd0);
      clear_req = (k == 5);
      reg_write = (k == 5);
      write_reg = 5'd3;
      if (k < 32) tick();
    end
    clear_req = 1'b0; reg_write = 1'b0;
    read_reg = {5'd5, 5'd7};
    expect_now(K_RD0, 32'd0);
    expect_now(K_RD1, 32'd0);
    tick();

    // Reset at clear cycle 10 restarts the full 32-cycle clear.
    reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h0000_0055;
    tick();
    reg_write = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_now(K_READY, 32'd0);
      tick();
    end
    rst_n = 1'b0;
    expect_now(K_READY, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      expect_now(K_READY, (k == 32) ? 32'd1 : 32'd0);
      if (k < 32) tick();
    end
    read_reg = {5'd5, 5'd4};
    expect_now(K_RD0, 32'd0);
    expect_now(K_RD1, 32'd0);
    tick();

`ifdef REG_FILE_MP_PARITY_EN
    // Corrupt one stored bit of r9 and check the parity flag on port 0.
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h0F0F_0F0F;
    tick();
    reg_write = 1'b0; read_reg = {5'd8, 5'd9};
    expect_now(K_PERR0, 32'd0);
    tick();
    dut.mem[9][3] = ~dut.mem[9][3];
    expect_now(K_PERR0, 32'd1);
    expect_now(K_RD0, 32'h0F0F_0F07);
    tick();
    read_reg = {5'd9, 5'd8};
    expect_now(K_PERR0, 32'd0);
    tick();
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      miscompares += sb.size();
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
